// File: rtl/vga_pixel_pipeline_if.sv
// Pixel-stream bundle between the VGA sync/position generator and the colour pipeline.
// The master drives position, raw syncs and freeze; the slave returns delayed syncs and RGB.
interface vga_pixel_pipeline_if #(
   parameter int unsigned COUNTER_SIZE = 11
);
   logic [COUNTER_SIZE-1:0] h_pos;
   logic [COUNTER_SIZE-1:0] v_pos;
   logic                    h_sync_in;
   logic                    v_sync_in;
   logic                    freeze;
   logic                    h_sync_out;
   logic                    v_sync_out;
   logic [11:0]             rgb;

   modport master (
      output h_pos, v_pos, h_sync_in, v_sync_in, freeze,
      input  h_sync_out, v_sync_out, rgb
   );

   modport slave (
      input  h_pos, v_pos, h_sync_in, v_sync_in, freeze,
      output h_sync_out, v_sync_out, rgb
   );
endinterface

// File: rtl/vga_pixel_pipeline.sv
// Two-stage colour pipeline: 8 vertical colour bars plus a bouncing sprite, syncs kept aligned.
// Define BORDER_EN to add a white 1-pixel frame around the active area.
module vga_pixel_pipeline #(
   parameter int unsigned COUNTER_SIZE = 11,
   parameter int unsigned H_ACTIVE     = 1024,
   parameter int unsigned V_ACTIVE     = 768,
   parameter int unsigned BAR_WIDTH    = 128,
   parameter int unsigned BOX_SIZE     = 32,
   parameter int unsigned STEP         = 2
) (
   input  logic                control_clock,
   input  logic                control_reset_n,
   vga_pixel_pipeline_if.slave pix
);
   localparam int unsigned W = COUNTER_SIZE + 1;

   logic [W-1:0]              h_ext, v_ext, bx_ext, by_ext;
   logic                      active_d, box_hit_d, tick;
   logic                      active_q, box_hit_q, border_s1;
   logic                      hs_s1_q, vs_s1_q;
   logic [COUNTER_SIZE-1:0]   bar_cnt_q, bar_cnt_d;
   logic [2:0]                bar_idx_q, bar_idx_d;
   logic [2:0]                bar_bits;
   logic [COUNTER_SIZE-1:0]   box_x_q, box_x_d, box_y_q, box_y_d;
   logic                      dir_x_neg_q, dir_x_neg_d, dir_y_neg_q, dir_y_neg_d;
   logic [11:0]               rgb_q, rgb_d;
   logic                      h_sync_q, v_sync_q;

   // Compare one bit wider than the counters so box_x+BOX_SIZE cannot wrap.
   assign h_ext  = {1'b0, pix.h_pos};
   assign v_ext  = {1'b0, pix.v_pos};
   assign bx_ext = {1'b0, box_x_q};
   assign by_ext = {1'b0, box_y_q};

   assign active_d  = (h_ext < W'(H_ACTIVE)) && (v_ext < W'(V_ACTIVE));
   assign box_hit_d = (h_ext >= bx_ext) && (h_ext < bx_ext + W'(BOX_SIZE)) &&
                      (v_ext >= by_ext) && (v_ext < by_ext + W'(BOX_SIZE));
   assign tick      = (pix.h_pos == '0) && (v_ext == W'(V_ACTIVE));

   // Returns {dir_neg, pos} after one frame of motion along one axis.
   function automatic logic [COUNTER_SIZE:0] bounce(input logic [COUNTER_SIZE-1:0] pos,
                                                    input logic neg, input logic [W-1:0] limit);
      logic [COUNTER_SIZE:0] res;
      if (!neg) begin
         if ({1'b0, pos} + W'(BOX_SIZE + STEP) >= limit) begin
            res = {1'b1, COUNTER_SIZE'(limit - W'(BOX_SIZE))};
         end else begin
            res = {1'b0, pos + COUNTER_SIZE'(STEP)};
         end
      end else if (pos <= COUNTER_SIZE'(STEP)) begin
         res = '0;
      end else begin
         res = {1'b1, pos - COUNTER_SIZE'(STEP)};
      end
      return res;
   endfunction

   always_comb begin
      {dir_x_neg_d, box_x_d} = {dir_x_neg_q, box_x_q};
      {dir_y_neg_d, box_y_d} = {dir_y_neg_q, box_y_q};
      if (tick && !pix.freeze) begin
         {dir_x_neg_d, box_x_d} = bounce(box_x_q, dir_x_neg_q, W'(H_ACTIVE));
         {dir_y_neg_d, box_y_d} = bounce(box_y_q, dir_y_neg_q, W'(V_ACTIVE));
      end
   end

   // bar_idx_q doubles as the stage-1 register: it holds the bar of the pixel just captured.
   always_comb begin
      bar_cnt_d = bar_cnt_q + 1'b1;
      bar_idx_d = bar_idx_q;
      if (pix.h_pos == '0) begin
         bar_cnt_d = '0;
         bar_idx_d = '0;
      end else if (bar_cnt_q == COUNTER_SIZE'(BAR_WIDTH - 1)) begin
         bar_cnt_d = '0;
         if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
      end
   end

`ifdef BORDER_EN
   logic border_d, border_q;
   assign border_d = active_d && ((pix.h_pos == '0) || (h_ext == W'(H_ACTIVE - 1)) ||
                                  (pix.v_pos == '0) || (v_ext == W'(V_ACTIVE - 1)));
   always_ff @(posedge control_clock or negedge control_reset_n) begin
      if (!control_reset_n) border_q <= 1'b0;
      else                  border_q <= border_d;
   end
   assign border_s1 = border_q;
`else
   assign border_s1 = 1'b0;
`endif

   always_ff @(posedge control_clock or negedge control_reset_n) begin
      if (!control_reset_n) begin
         active_q    <= 1'b0;
         box_hit_q   <= 1'b0;
         hs_s1_q     <= 1'b0;
         vs_s1_q     <= 1'b0;
         bar_cnt_q   <= '0;
         bar_idx_q   <= '0;
         box_x_q     <= '0;
         box_y_q     <= '0;
         dir_x_neg_q <= 1'b0;
         dir_y_neg_q <= 1'b0;
      end else begin
         active_q    <= active_d;
         box_hit_q   <= box_hit_d;
         hs_s1_q     <= pix.h_sync_in;
         vs_s1_q     <= pix.v_sync_in;
         bar_cnt_q   <= bar_cnt_d;
         bar_idx_q   <= bar_idx_d;
         box_x_q     <= box_x_d;
         box_y_q     <= box_y_d;
         dir_x_neg_q <= dir_x_neg_d;
         dir_y_neg_q <= dir_y_neg_d;
      end
   end

   // Bar order white,yellow,cyan,green,magenta,red,blue,black reduces to inverted index bits.
   assign bar_bits = {~bar_idx_q[1], ~bar_idx_q[2], ~bar_idx_q[0]};

   always_comb begin
      rgb_d = {{4{bar_bits[2]}}, {4{bar_bits[1]}}, {4{bar_bits[0]}}};
      if (!active_q)      rgb_d = 12'h000;
      else if (border_s1) rgb_d = 12'hFFF;
      else if (box_hit_q) rgb_d = 12'hF80;
   end

   always_ff @(posedge control_clock or negedge control_reset_n) begin
      if (!control_reset_n) begin
         rgb_q    <= '0;
         h_sync_q <= 1'b0;
         v_sync_q <= 1'b0;
      end else begin
         rgb_q    <= rgb_d;
         h_sync_q <= hs_s1_q;
         v_sync_q <= vs_s1_q;
      end
   end

   assign pix.rgb        = rgb_q;
   assign pix.h_sync_out = h_sync_q;
   assign pix.v_sync_out = v_sync_q;
endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// Bench for vga_pixel_pipeline: directed corner cases plus random scans/ticks against a
// behavioural frame model (bars from pixel count, sprite from the bounce rules).
module tb_vga_pixel_pipeline;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   vga_pixel_pipeline_if #(.COUNTER_SIZE(11)) pix ();

   vga_pixel_pipeline dut (
      .control_clock   (clk),
      .control_reset_n (rst_n),
      .pix             (pix)
   );

   int n_chk = 0;
   int n_bad = 0;

   logic [11:0] bar_tab [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                12'hF0F, 12'hF00, 12'h00F, 12'h000};

   // Reference state
   int          bx, by, bar_n, prev_h, prev_v;
   bit          bx_neg, by_neg, hs_prev, vs_prev;
   logic [11:0] exp_prev;
   logic [11:0] line_rgb [0:1199];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic move_axis(inout int p, inout bit neg, input int lim);
      if (!neg) begin
         if (p + 32 + 2 >= lim) begin p = lim - 32; neg = 1'b1; end
         else p = p + 2;
      end else begin
         if (p <= 2) begin p = 0; neg = 1'b0; end
         else p = p - 2;
      end
   endtask

   function automatic logic [11:0] model_rgb(input int h, input int v);
      int idx;
      if (h >= 1024 || v >= 768) return 12'h000;
`ifdef BORDER_EN
      if (h == 0 || h == 1023 || v == 0 || v == 767) return 12'hFFF;
`endif
      if (h >= bx && h < bx + 32 && v >= by && v < by + 32) return 12'hF80;
      idx = bar_n / 128;
      if (idx > 7) idx = 7;
      return bar_tab[idx];
   endfunction

   // Drives one pixel, clocks once, checks the outputs for the pixel driven one step earlier.
   task automatic step(input int h, input int v, input bit hs, input bit vs, input bit frz);
      logic [11:0] e;
      pix.h_pos     = 11'(h);
      pix.v_pos     = 11'(v);
      pix.h_sync_in = hs;
      pix.v_sync_in = vs;
      pix.freeze    = frz;
      bar_n = (h == 0) ? 0 : bar_n + 1;
      e = model_rgb(h, v);
      @(posedge clk);
      #1;
      check($sformatf("rgb(%0d,%0d)", prev_h, prev_v), 32'(pix.rgb), 32'(exp_prev));
      check("h_sync_out", 32'(pix.h_sync_out), 32'(hs_prev));
      check("v_sync_out", 32'(pix.v_sync_out), 32'(vs_prev));
      exp_prev = e;
      hs_prev  = hs;
      vs_prev  = vs;
      prev_h   = h;
      prev_v   = v;
      if (h == 0 && v == 768 && !frz) begin
         move_axis(bx, bx_neg, 1024);
         move_axis(by, by_neg, 768);
      end
   endtask

   task automatic tick(input bit frz);
      step(0, 768, 1'b0, 1'b1, frz);
   endtask

   task automatic scan(input int v);
      for (int h = 0; h <= 1100; h++) begin
         step(h, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
         if (h > 0) line_rgb[h-1] = pix.rgb;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_rgb", 32'(pix.rgb), 32'h0);
      check("rst_hsync", 32'(pix.h_sync_out), 32'h0);
      check("rst_vsync", 32'(pix.v_sync_out), 32'h0);
      @(negedge clk);
      rst_n    = 1'b1;
      bx       = 0;
      by       = 0;
      bx_neg   = 1'b0;
      by_neg   = 1'b0;
      bar_n    = 0;
      exp_prev = 12'h000;
      hs_prev  = 1'b0;
      vs_prev  = 1'b0;
      prev_h   = -1;
      prev_v   = -1;
   endtask

   initial begin
      pix.h_pos     = '0;
      pix.v_pos     = '0;
      pix.h_sync_in = 1'b0;
      pix.v_sync_in = 1'b0;
      pix.freeze    = 1'b0;

      // Box at origin, 2-cycle latency for colour and syncs
      do_reset();
      step(5, 5, 1'b1, 1'b0, 1'b0);
      step(6, 5, 1'b0, 1'b0, 1'b0);
      check("t1_box_rgb", 32'(pix.rgb), 32'hF80);
      check("t1_hsync", 32'(pix.h_sync_out), 32'h1);

      // Bar boundaries and blanking
      do_reset();
      scan(100);
      check("t2_h0", 32'(line_rgb[0]), 32'hFFF);
      check("t2_h127", 32'(line_rgb[127]), 32'hFFF);
      check("t2_h128", 32'(line_rgb[128]), 32'hFF0);
      check("t2_h896", 32'(line_rgb[896]), 32'h000);
      check("t2_h1000", 32'(line_rgb[1000]), 32'h000);
      check("t2_h1024", 32'(line_rgb[1024]), 32'h000);

      // One tick moves the box to (2,2)
      tick(1'b0);
      scan(1);
      check("t3_pix11", 32'(line_rgb[1]), 32'hFFF);
      scan(2);
      check("t3_pix22", 32'(line_rgb[2]), 32'hF80);
      check("t3_pix12", 32'(line_rgb[1]), 32'hFFF);

      // Edge pixels with and without the border
      do_reset();
      scan(0);
`ifdef BORDER_EN
      check("t6_box_edge", 32'(line_rgb[5]), 32'hFFF);
      check("t6_top_200", 32'(line_rgb[200]), 32'hFFF);
`else
      check("t6_box_edge", 32'(line_rgb[5]), 32'hF80);
      check("t6_top_200", 32'(line_rgb[200]), 32'hFF0);
`endif
      scan(40);
      check("t6_left_40", 32'(line_rgb[0]), 32'hFFF);
      scan(700);
`ifdef BORDER_EN
      check("t6_right_700", 32'(line_rgb[1023]), 32'hFFF);
`else
      check("t6_right_700", 32'(line_rgb[1023]), 32'h000);
`endif

      // Right wall bounce
      do_reset();
      repeat (495) tick(1'b0);
      scan(by + 1);
      check("t4_x990_in", 32'(line_rgb[990]), 32'hF80);
      check("t4_x990_out", 32'(line_rgb[989]), 32'h000);
      tick(1'b0);
      scan(by + 1);
      check("t4_x992_in", 32'(line_rgb[992]), 32'hF80);
      check("t4_x992_out", 32'(line_rgb[991]), 32'h000);
      tick(1'b0);
      scan(by + 1);
      check("t4_back990_in", 32'(line_rgb[990]), 32'hF80);
      check("t4_back990_out", 32'(line_rgb[989]), 32'h000);

      // Left wall bounce: 990 -> 0 takes 495 ticks
      repeat (495) tick(1'b0);
      scan(by + 1);
      check("t4_x0_in", 32'(line_rgb[31]), 32'hF80);
      check("t4_x0_out", 32'(line_rgb[32]), 32'hFFF);
      tick(1'b0);
      scan(by + 1);
      check("t4_x2_in", 32'(line_rgb[2]), 32'hF80);
      check("t4_x2_out", 32'(line_rgb[1]), 32'hFFF);

      // Freeze holds across ticks, release moves by one step
      repeat (3) tick(1'b1);
      scan(by + 1);
      check("t5_frozen_in", 32'(line_rgb[2]), 32'hF80);
      check("t5_frozen_out", 32'(line_rgb[1]), 32'hFFF);
      tick(1'b0);
      scan(by + 1);
      check("t5_moved_in", 32'(line_rgb[4]), 32'hF80);
      check("t5_moved_out", 32'(line_rgb[3]), 32'hFFF);

      // Mid-line reset flushes the pipeline
      for (int h = 0; h < 20; h++) step(h, 100, 1'b1, 1'b1, 1'b0);
      do_reset();
      check("rst_release_rgb", 32'(pix.rgb), 32'h0);
      step(40, 300, 1'b1, 1'b1, 1'b0);
      step(41, 300, 1'b1, 1'b1, 1'b0);

      // Random mix of tick bursts, line scans and scattered pixels
      for (int it = 0; it < 30; it++) begin
         case ($urandom_range(0, 2))
            0: repeat ($urandom_range(1, 200)) tick(1'($urandom_range(0, 3) == 0));
            1: scan(int'($urandom_range(0, 799)));
            default: begin
               repeat (50) begin
                  step(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
               end
            end
         endcase
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
